// File: rtl/controller_pkg.sv
// controller_pkg
// Shared definitions for the NES-style controller reader:
//   - ctrl_state_t : fetch sequencer states
//   - BTN_*        : bit position of each button inside a button byte
package controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    COMMIT
  } ctrl_state_t;

  // The first serial bit (A) ends up in the MSB after eight left shifts.
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Single-bit two-flop synchronizer for an asynchronous input.
// Ports:
//   i_clk : destination clock
//   i_rst : synchronous active-high reset, clears both flops
//   i_d   : asynchronous input bit
//   o_q   : synchronized bit, two cycles of latency
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/controller_interface.sv
// controller_interface
// Reads two NES-style shift-register pads once per frame and presents one
// stable button byte per pad on the CPU data bus.
// Ports:
//   gpu_clk, rst               : clock and synchronous active-high reset
//   start_fetch                : GPU frame strobe; its rising edge starts a fetch
//   ctrl_latch, ctrl_clk       : latch and shift clock to both pads (registered)
//   ctrl_data_1, ctrl_data_2   : active-low asynchronous serial data from the pads
//   SELECT_ctrl1, SELECT_ctrl2 : CPU read selects (pad 1 wins when both are set)
//   data_out                   : selected button byte, high-Z when unselected
//   busy                       : a fetch is in progress
//   fetch_done                 : one-cycle pulse when new button bytes commit
module controller_interface
  import controller_pkg::*;
#(
  parameter int HALF_PERIOD = 150
) (
  input  logic       gpu_clk,
  input  logic       rst,
  input  logic       start_fetch,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  input  logic       ctrl_data_1,
  input  logic       ctrl_data_2,
  input  logic       SELECT_ctrl1,
  input  logic       SELECT_ctrl2,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       fetch_done
);

  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);

  ctrl_state_t   r_state;
  logic [PW-1:0] r_phase;
  logic [2:0]    r_bit;
  logic          r_latch;
  logic          r_clk;
  logic          r_done;
  logic          r_startPrev;
  logic [7:0]    r_shadow1;
  logic [7:0]    r_shadow2;
  logic [7:0]    r_buttons1;
  logic [7:0]    r_buttons2;
  logic          w_sync1;
  logic          w_sync2;
  logic          w_startEdge;

  sync_2ff u_sync1 (
    .i_clk (gpu_clk),
    .i_rst (rst),
    .i_d   (ctrl_data_1),
    .o_q   (w_sync1)
  );

  sync_2ff u_sync2 (
    .i_clk (gpu_clk),
    .i_rst (rst),
    .i_d   (ctrl_data_2),
    .o_q   (w_sync2)
  );

  // start_prev clears on reset, so a level held high through reset release
  // is seen as an edge and starts a fetch.
  assign w_startEdge = start_fetch & ~r_startPrev;

  // Sequencer: pad pins and the commit pulse are registered together with the
  // state so they change on exactly the cycle the state does. Shadow registers
  // collect the frame; only COMMIT copies them to the CPU-visible bytes, so a
  // read never sees a partial frame and a reset never causes a partial commit.
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_bit       <= '0;
      r_latch     <= 1'b0;
      r_clk       <= 1'b1;
      r_done      <= 1'b0;
      r_startPrev <= 1'b0;
      r_shadow1   <= '0;
      r_shadow2   <= '0;
      r_buttons1  <= '0;
      r_buttons2  <= '0;
    end else begin
      r_startPrev <= start_fetch;
      r_done      <= 1'b0;
      r_phase     <= r_phase + 1'b1;
      case (r_state)
        IDLE: begin
          r_phase <= '0;
          if (w_startEdge) begin
            r_state <= LATCH;
            r_latch <= 1'b1;
            r_clk   <= 1'b1;
          end
        end
        LATCH: begin
          if (r_phase == LATCH_LAST) begin
            r_state <= LOW;
            r_latch <= 1'b0;
            r_clk   <= 1'b0;
            r_phase <= '0;
            r_bit   <= '0;
          end
        end
        LOW: begin
          // Sample at the end of the low half, just before the pad's rising
          // shift clock; the pad line is active-low, so invert.
          if (r_phase == HALF_LAST) begin
            r_shadow1 <= {r_shadow1[BTN_A-1:BTN_RIGHT], ~w_sync1};
            r_shadow2 <= {r_shadow2[BTN_A-1:BTN_RIGHT], ~w_sync2};
            r_state   <= HIGH;
            r_clk     <= 1'b1;
            r_phase   <= '0;
          end
        end
        HIGH: begin
          if (r_phase == HALF_LAST) begin
            r_phase <= '0;
            if (r_bit == 3'd7) begin
              r_state <= COMMIT;
              r_done  <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_state <= LOW;
              r_clk   <= 1'b0;
            end
          end
        end
        COMMIT: begin
          r_buttons1 <= r_shadow1;
          r_buttons2 <= r_shadow2;
          r_state    <= IDLE;
          r_phase    <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_latch <= 1'b0;
          r_clk   <= 1'b1;
          r_phase <= '0;
        end
      endcase
    end
  end

  assign ctrl_latch = r_latch;
  assign ctrl_clk   = r_clk;
  assign fetch_done = r_done;
  assign busy       = (r_state != IDLE);

  // Pad 1 has priority when the CPU asserts both selects.
  assign data_out = SELECT_ctrl1 ? r_buttons1 :
                    SELECT_ctrl2 ? r_buttons2 : 8'hzz;

endmodule

// File: tb/tb_controller_interface.sv
// tb_controller_interface
// Directed bench for controller_interface with HALF_PERIOD = 4, using a
// behavioural model of two NES pads. The data bus is a pulled-up net, so an
// undriven bus reads 8'hFF.
module tb_controller_interface;
  import controller_pkg::*;

  logic       gpu_clk;
  logic       rst;
  logic       start_fetch;
  logic       ctrl_latch;
  logic       ctrl_clk;
  logic       ctrl_data_1;
  logic       ctrl_data_2;
  logic       SELECT_ctrl1;
  logic       SELECT_ctrl2;
  tri1  [7:0] dataBus;
  logic       busy;
  logic       fetch_done;

  int totalChecks;
  int badChecks;

  logic [7:0] pad1Buttons;
  logic [7:0] pad2Buttons;
  logic [7:0] padShift1;
  logic [7:0] padShift2;
  logic       padPrevClk;

  controller_interface #(.HALF_PERIOD(4)) dut (
    .gpu_clk      (gpu_clk),
    .rst          (rst),
    .start_fetch  (start_fetch),
    .ctrl_latch   (ctrl_latch),
    .ctrl_clk     (ctrl_clk),
    .ctrl_data_1  (ctrl_data_1),
    .ctrl_data_2  (ctrl_data_2),
    .SELECT_ctrl1 (SELECT_ctrl1),
    .SELECT_ctrl2 (SELECT_ctrl2),
    .data_out     (dataBus),
    .busy         (busy),
    .fetch_done   (fetch_done)
  );

  initial gpu_clk = 1'b0;
  always #5 gpu_clk = ~gpu_clk;

  // Pad model: loads while latch is high, shifts on each rising pad clock,
  // drives its current MSB active-low.
  always @(posedge gpu_clk) begin
    padPrevClk <= ctrl_clk;
    if (ctrl_latch) begin
      padShift1 <= pad1Buttons;
      padShift2 <= pad2Buttons;
    end else if (ctrl_clk && !padPrevClk) begin
      padShift1 <= {padShift1[6:0], 1'b0};
      padShift2 <= {padShift2[6:0], 1'b0};
    end
  end

  assign ctrl_data_1 = ~padShift1[7];
  assign ctrl_data_2 = ~padShift2[7];

  task automatic nextCycle();
    @(posedge gpu_clk);
    @(negedge gpu_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_fetch = 1'b0;
    SELECT_ctrl1 = 1'b0;
    SELECT_ctrl2 = 1'b0;
    repeat (3) nextCycle();
    rst = 1'b0;
    repeat (3) nextCycle();
    totalChecks++;
    if ({ctrl_latch, ctrl_clk, busy, fetch_done} !== 4'b0100) begin
      badChecks++;
      $display("[TB] FAIL reset_pins got=%b want=0100", {ctrl_latch, ctrl_clk, busy, fetch_done});
    end
    #1;
    totalChecks++;
    if (dataBus !== 8'hFF) begin
      badChecks++;
      $display("[TB] FAIL reset_highz got=%h want=ff", dataBus);
    end
    SELECT_ctrl1 = 1'b1;
    #1;
    totalChecks++;
    if (dataBus !== 8'h00) begin
      badChecks++;
      $display("[TB] FAIL reset_sel1 got=%h want=00", dataBus);
    end
    SELECT_ctrl1 = 1'b0;
    SELECT_ctrl2 = 1'b1;
    #1;
    totalChecks++;
    if (dataBus !== 8'h00) begin
      badChecks++;
      $display("[TB] FAIL reset_sel2 got=%h want=00", dataBus);
    end
    SELECT_ctrl2 = 1'b0;
  endtask

  // Full fetch with per-cycle pin checks while pad 1 is polled throughout.
  // Start edge is sampled at the end of cycle N; loop index k is cycle N+k.
  task automatic test_fetch(input logic [7:0] p1, input logic [7:0] p2,
                            input logic [7:0] exp1, input logic [7:0] exp2,
                            input logic [7:0] old1);
    logic [3:0] expPins;
    logic [7:0] expData;
    logic       lowPhase;
    pad1Buttons = p1;
    pad2Buttons = p2;
    SELECT_ctrl1 = 1'b1;
    SELECT_ctrl2 = 1'b0;
    start_fetch = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      nextCycle();
      if (k == 32) start_fetch = 1'b0;
      lowPhase = (k >= 9) && (k <= 72) && (((k - 9) % 8) < 4);
      expPins = {(k <= 8), !lowPhase, (k <= 73), (k == 73)};
      expData = (k >= 74) ? exp1 : old1;
      #1;
      totalChecks++;
      if ({ctrl_latch, ctrl_clk, busy, fetch_done} !== expPins || dataBus !== expData) begin
        badChecks++;
        $display("[TB] FAIL fetch_cycle k=%0d got=%b/%h want=%b/%h", k,
                 {ctrl_latch, ctrl_clk, busy, fetch_done}, dataBus, expPins, expData);
      end
    end
    SELECT_ctrl1 = 1'b0;
    SELECT_ctrl2 = 1'b1;
    #1;
    totalChecks++;
    if (dataBus !== exp2) begin
      badChecks++;
      $display("[TB] FAIL fetch_sel2 got=%h want=%h", dataBus, exp2);
    end
    SELECT_ctrl2 = 1'b0;
  endtask

  // Level held for 32 cycles plus a second pulse while busy: one fetch only.
  task automatic test_no_retrigger();
    int doneCount;
    doneCount = 0;
    start_fetch = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      nextCycle();
      if (k == 32) start_fetch = 1'b0;
      if (k == 40) start_fetch = 1'b1;
      if (k == 46) start_fetch = 1'b0;
      if (fetch_done) doneCount++;
    end
    totalChecks++;
    if (doneCount !== 1 || busy !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL no_retrigger done=%0d busy=%b want done=1 busy=0", doneCount, busy);
    end
  endtask

  // Start held across the fetch, then a fresh edge in the COMMIT cycle.
  task automatic test_back_to_back();
    int doneCount;
    int busyCount;
    doneCount = 0;
    busyCount = 0;
    start_fetch = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      nextCycle();
      if (k == 60) start_fetch = 1'b0;
      if (k == 73) start_fetch = 1'b1;
      if (fetch_done) doneCount++;
      if (k >= 74 && busy) busyCount++;
    end
    start_fetch = 1'b0;
    totalChecks++;
    if (doneCount !== 1 || busyCount !== 0) begin
      badChecks++;
      $display("[TB] FAIL commit_edge done=%0d busyAfter=%0d want 1/0", doneCount, busyCount);
    end
  endtask

  // Reset in the fifth LOW phase (cycles 41..44) aborts without committing.
  task automatic test_reset_mid_fetch();
    int doneCount;
    pad1Buttons = 8'h33;
    pad2Buttons = 8'hCC;
    start_fetch = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      nextCycle();
      if (k == 32) start_fetch = 1'b0;
    end
    rst = 1'b1;
    nextCycle();
    totalChecks++;
    if ({ctrl_latch, ctrl_clk, busy, fetch_done} !== 4'b0100) begin
      badChecks++;
      $display("[TB] FAIL abort_pins got=%b want=0100", {ctrl_latch, ctrl_clk, busy, fetch_done});
    end
    SELECT_ctrl1 = 1'b1;
    #1;
    totalChecks++;
    if (dataBus !== 8'h00) begin
      badChecks++;
      $display("[TB] FAIL abort_sel1 got=%h want=00", dataBus);
    end
    SELECT_ctrl1 = 1'b0;
    SELECT_ctrl2 = 1'b1;
    #1;
    totalChecks++;
    if (dataBus !== 8'h00) begin
      badChecks++;
      $display("[TB] FAIL abort_sel2 got=%h want=00", dataBus);
    end
    SELECT_ctrl2 = 1'b0;
    rst = 1'b0;
    doneCount = 0;
    for (int k = 0; k < 100; k++) begin
      nextCycle();
      if (fetch_done || busy) doneCount++;
    end
    totalChecks++;
    if (doneCount !== 0) begin
      badChecks++;
      $display("[TB] FAIL abort_quiet activeCycles=%0d want=0", doneCount);
    end
  endtask

  task automatic test_both_selects();
    SELECT_ctrl1 = 1'b1;
    SELECT_ctrl2 = 1'b1;
    #1;
    totalChecks++;
    if (dataBus !== 8'h90) begin
      badChecks++;
      $display("[TB] FAIL both_sel got=%h want=90", dataBus);
    end
    SELECT_ctrl1 = 1'b0;
    SELECT_ctrl2 = 1'b0;
    #1;
    totalChecks++;
    if (dataBus !== 8'hFF) begin
      badChecks++;
      $display("[TB] FAIL no_sel got=%h want=ff", dataBus);
    end
  endtask

  initial begin
    logic [7:0] allPressed;
    logic [7:0] aStart;
    logic [7:0] rightOnly;
    totalChecks = 0;
    badChecks = 0;
    rst = 1'b1;
    start_fetch = 1'b0;
    SELECT_ctrl1 = 1'b0;
    SELECT_ctrl2 = 1'b0;
    pad1Buttons = 8'h00;
    pad2Buttons = 8'h00;
    allPressed = 8'(1 << BTN_A) | 8'(1 << BTN_B) | 8'(1 << BTN_SELECT) | 8'(1 << BTN_START)
               | 8'(1 << BTN_UP) | 8'(1 << BTN_DOWN) | 8'(1 << BTN_LEFT) | 8'(1 << BTN_RIGHT);
    aStart = 8'(1 << BTN_A) | 8'(1 << BTN_START);
    rightOnly = 8'(1 << BTN_RIGHT);

    test_reset();
    test_fetch(allPressed, allPressed, 8'hFF, 8'hFF, 8'h00);
    nextCycle();
    test_fetch(aStart, rightOnly, 8'h90, 8'h01, 8'hFF);
    nextCycle();
    test_no_retrigger();
    test_back_to_back();
    nextCycle();
    test_reset_mid_fetch();
    test_fetch(aStart, rightOnly, 8'h90, 8'h01, 8'h00);
    test_both_selects();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
